// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment codes are active-low a..g; the dp bit is appended separately.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0001100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] EN_OFF  = 4'b1111;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble + dp + blank to an active-low {a..g, dp} segment code.
// Non-decimal nibbles show a dash; blanking keeps the dp honoured.
module bcd_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [6:0] code;

  always_comb begin
    code = SEG_DASH;
    unique case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
    seg = {blank ? 7'h7F : code, ~dp};
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed scan controller with a pending load buffer
// that commits at frame boundaries and blank gaps between digits.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500,
  parameter int CNT_W       = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        lzb,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_digits,
  input  logic [3:0]  load_dp,
  output logic [3:0]  enable,
  output logic [7:0]  sevenseg,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK_TICKS - 1);

  scan_state_e state_q, state_d;
  logic [1:0]       dig_q, dig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      act_dig_q, act_dig_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic [15:0]      pend_dig_q, pend_dig_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pending_q, pending_d;
  logic [3:0]       en_q, en_d;
  logic [7:0]       seg_q, seg_d;
  logic             fd_q, fd_d;

  logic       commit;
  logic [3:0] nib;
  logic       dp_sel;
  logic       blank;
  logic       z3, z2, z1;
  logic [7:0] dec_seg;

  assign load_ready = ~pending_q;
  assign enable     = en_q;
  assign sevenseg   = seg_q;
  assign frame_done = fd_q;

  assign nib    = act_dig_q[{dig_q, 2'b00} +: 4];
  assign dp_sel = act_dp_q[dig_q];
  assign z3     = (act_dig_q[15:12] == 4'd0);
  assign z2     = (act_dig_q[11:8] == 4'd0);
  assign z1     = (act_dig_q[7:4] == 4'd0);

  // Blanking cascades down from the most significant digit.
  always_comb begin
    blank = 1'b0;
    unique case (dig_q)
      2'd3:    blank = lzb & z3;
      2'd2:    blank = lzb & z3 & z2;
      2'd1:    blank = lzb & z3 & z2 & z1;
      default: blank = 1'b0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .nib   (nib),
    .dp    (dp_sel),
    .blank (blank),
    .seg   (dec_seg)
  );

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;
    en_d       = en_q;
    seg_d      = seg_q;
    fd_d       = 1'b0;
    commit     = 1'b0;

    if (!run) begin
      state_d = ST_BLANK;
      dig_d   = 2'd0;
      cnt_d   = '0;
      en_d    = EN_OFF;
      seg_d   = SEG_OFF;
      commit  = pending_q;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == B_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            en_d    = ~(4'b0001 << dig_q);
            seg_d   = dec_seg;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == D_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            dig_d   = dig_q + 2'd1;
            en_d    = EN_OFF;
            seg_d   = SEG_OFF;
            if (dig_q == 2'd3) begin
              fd_d   = 1'b1;
              commit = pending_q;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    // Commit needs pending set, a load needs it clear: never both.
    if (commit) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
      pending_d = 1'b0;
    end
    if (load_valid && !pending_q) begin
      pend_dig_d = load_digits;
      pend_dp_d  = load_dp;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_BLANK;
      dig_q      <= 2'd0;
      cnt_q      <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      en_q       <= EN_OFF;
      seg_q      <= SEG_OFF;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      en_q       <= en_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with short scan timing.
// Stimulus queues cycle-stamped expectations; a negedge monitor checks.
module tb_seven_seg_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        run = 1'b1;
  logic        lzb = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_digits = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  enable;
  logic [7:0]  sevenseg;
  logic        frame_done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [7:0] seg;
    logic       fd;
    logic       rdy;
    bit         co;
    bit         cr;
  } exp_t;

  exp_t sb[$];

  seven_seg_scan_ctrl #(
    .DIGIT_TICKS (4),
    .BLANK_TICKS (2),
    .CNT_W       (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .lzb         (lzb),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_dp     (load_dp),
    .enable      (enable),
    .sevenseg    (sevenseg),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void push(exp_t e);
    int i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endfunction

  task automatic push_out(int c, logic [3:0] en, logic [7:0] seg,
                          logic fd);
    exp_t e;
    e.cyc = c; e.en = en; e.seg = seg; e.fd = fd;
    e.rdy = 1'b0; e.co = 1'b1; e.cr = 1'b0;
    push(e);
  endtask

  task automatic push_rdy(int c, logic r);
    exp_t e;
    e.cyc = c; e.en = '0; e.seg = '0; e.fd = 1'b0;
    e.rdy = r; e.co = 1'b0; e.cr = 1'b1;
    push(e);
  endtask

  // Blank 2 cycles then drive 4 cycles, digits 0..3 in order.
  task automatic expect_frame(int f, int len, logic fd0,
                              logic [7:0] s3, logic [7:0] s2,
                              logic [7:0] s1, logic [7:0] s0);
    logic [7:0] s[4];
    logic [3:0] en;
    int d, p;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < len; k++) begin
      d = k / 6;
      p = k % 6;
      if (p < 2) begin
        push_out(f + k, 4'b1111, 8'hFF, (k == 0) ? fd0 : 1'b0);
      end else begin
        en = ~(4'b0001 << d);
        push_out(f + k, en, s[d], 1'b0);
      end
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL stale cyc=%0d: checked at %0d, required %0d",
                 e.cyc, cyc, e.cyc);
      end else begin
        if (e.co) begin
          checks++;
          if ({enable, sevenseg, frame_done} !== {e.en, e.seg, e.fd}) begin
            errors++;
            $display("FAIL out cyc=%0d: got en=%b seg=%h fd=%b, want en=%b seg=%h fd=%b",
                     cyc, enable, sevenseg, frame_done, e.en, e.seg, e.fd);
          end
        end
        if (e.cr) begin
          checks++;
          if (load_ready !== e.rdy) begin
            errors++;
            $display("FAIL ready cyc=%0d: got %b, want %b",
                     cyc, load_ready, e.rdy);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    #0 reset_n = 1'b0;
    push_out(1, 4'b1111, 8'hFF, 1'b0);
    push_out(2, 4'b1111, 8'hFF, 1'b0);
    push_rdy(1, 1'b1);
    expect_frame(2, 24, 1'b0, 8'h03, 8'h03, 8'h03, 8'h03);
    wait_cyc(2);
    reset_n = 1'b1;

    wait_cyc(12);
    push_rdy(12, 1'b1);
    push_rdy(13, 1'b0);
    push_rdy(25, 1'b0);
    push_rdy(26, 1'b1);
    load_valid  = 1'b1;
    load_digits = 16'h1234;
    load_dp     = 4'b0001;
    wait_cyc(13);
    load_valid = 1'b0;
    expect_frame(26, 24, 1'b1, 8'h9F, 8'h25, 8'h0D, 8'h98);

    wait_cyc(30);
    load_valid  = 1'b1;
    load_digits = 16'h0070;
    load_dp     = 4'b0000;
    push_rdy(31, 1'b0);
    wait_cyc(31);
    load_valid = 1'b0;

    wait_cyc(32);
    lzb         = 1'b1;
    load_valid  = 1'b1;
    load_digits = 16'h0000;
    load_dp     = 4'b0000;
    push_rdy(49, 1'b0);
    push_rdy(50, 1'b1);
    push_rdy(51, 1'b0);
    expect_frame(50, 24, 1'b1, 8'hFF, 8'hFF, 8'h1F, 8'h03);
    wait_cyc(51);
    load_valid = 1'b0;
    expect_frame(74, 16, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h03);
    push_rdy(74, 1'b1);

    wait_cyc(80);
    load_valid  = 1'b1;
    load_digits = 16'h00B5;
    load_dp     = 4'b0010;
    push_rdy(81, 1'b0);
    wait_cyc(81);
    load_valid = 1'b0;

    wait_cyc(89);
    run = 1'b0;
    push_out(90, 4'b1111, 8'hFF, 1'b0);
    push_out(91, 4'b1111, 8'hFF, 1'b0);
    push_rdy(90, 1'b1);
    expect_frame(92, 10, 1'b0, 8'hFF, 8'hFF, 8'hFC, 8'h49);
    wait_cyc(92);
    run = 1'b1;

    wait_cyc(100);
    load_valid  = 1'b1;
    load_digits = 16'h9999;
    load_dp     = 4'b1111;
    push_rdy(101, 1'b0);
    wait_cyc(101);
    load_valid = 1'b0;

    wait_cyc(102);
    reset_n = 1'b0;
    push_out(102, 4'b1111, 8'hFF, 1'b0);
    push_out(103, 4'b1111, 8'hFF, 1'b0);
    push_rdy(102, 1'b1);
    expect_frame(104, 24, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h03);
    expect_frame(128, 6, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h03);
    push_rdy(128, 1'b1);
    wait_cyc(104);
    reset_n = 1'b1;

    wait_cyc(134);
    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(posedge clock);
      guard++;
    end
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
